// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings for the divide issue controller: op codes, FSM states, default width.
package div_issue_ctrl_pkg;

   localparam int unsigned DATAWIDTH_DEF = 32;
   localparam int unsigned RD_W          = 5;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      KILL = 2'b10,
      DONE = 2'b11
   } state_e;

endpackage

// File: rtl/div_special_case.sv
// Detects ops the divider must not see (zero divisor, signed MIN/-1) and supplies their result.
module div_special_case
   import div_issue_ctrl_pkg::*;
#(
   parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
) (
   input  logic [1:0]           op,
   input  logic [DATAWIDTH-1:0] rs1,
   input  logic [DATAWIDTH-1:0] rs2,
   output logic                 is_special_c,
   output logic [DATAWIDTH-1:0] result_c
);

   localparam logic [DATAWIDTH-1:0] MIN_VAL = {1'b1, {(DATAWIDTH-1){1'b0}}};

   logic zero_div;
   logic sgn_ovf;

   always_comb begin
      zero_div     = (rs2 == '0);
      sgn_ovf      = !op[0] && (rs1 == MIN_VAL) && (rs2 == '1);
      is_special_c = zero_div || sgn_ovf;
      result_c     = '0;
      // op[1] selects the remainder flavour
      if (zero_div) begin
         result_c = op[1] ? rs1 : '1;
      end else if (sgn_ovf) begin
         result_c = op[1] ? '0 : MIN_VAL;
      end
   end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/sequencing stage in front of the iterative divider.
// Optional result cache for repeated operands is built when DIV_REUSE_EN is defined.
module div_issue_ctrl
   import div_issue_ctrl_pkg::*;
#(
   parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ex_valid,
   output logic                 ex_ready,
   input  logic [1:0]           ex_op,
   input  logic [DATAWIDTH-1:0] ex_rs1,
   input  logic [DATAWIDTH-1:0] ex_rs2,
   input  logic [4:0]           ex_rd,
   input  logic                 flush,
   output logic                 div_en,
   output logic                 div_unsigned,
   output logic [DATAWIDTH-1:0] div_dividend,
   output logic [DATAWIDTH-1:0] div_divisor,
   input  logic [DATAWIDTH-1:0] div_quotient,
   input  logic [DATAWIDTH-1:0] div_remainder,
   input  logic                 div_end,
   output logic                 wb_valid,
   input  logic                 wb_ready,
   output logic [4:0]           wb_rd,
   output logic [DATAWIDTH-1:0] wb_data,
   output logic                 err_timeout
);

   localparam int unsigned       CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);

   state_e                 state_q, state_d;
   logic                   is_rem_q, is_rem_d;
   logic                   uns_q, uns_d;
   logic [DATAWIDTH-1:0]   rs1_q, rs1_d;
   logic [DATAWIDTH-1:0]   rs2_q, rs2_d;
   logic [RD_W-1:0]        rd_q, rd_d;
   logic [DATAWIDTH-1:0]   wb_data_q, wb_data_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic                   div_en_q, div_en_d;
   logic                   wb_valid_q, wb_valid_d;
   logic                   ex_ready_q, ex_ready_d;

   logic                   accept;
   logic                   tmo_fire;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   spec_c;
   logic [DATAWIDTH-1:0]   spec_result_c;
   logic                   cache_hit_c;
   logic [DATAWIDTH-1:0]   cache_data_c;

   div_special_case #(.DATAWIDTH(DATAWIDTH)) u_special (
      .op          (ex_op),
      .rs1         (ex_rs1),
      .rs2         (ex_rs2),
      .is_special_c(spec_c),
      .result_c    (spec_result_c)
   );

   assign accept  = ex_valid && ex_ready_q;
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   // Next state and registered-output decode
   always_comb begin
      state_d   = state_q;
      is_rem_d  = is_rem_q;
      uns_d     = uns_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      rd_d      = rd_q;
      wb_data_d = wb_data_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      tmo_fire  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               is_rem_d = ex_op[1];
               uns_d    = ex_op[0];
               rs1_d    = ex_rs1;
               rs2_d    = ex_rs2;
               rd_d     = ex_rd;
               cnt_d    = '0;
               if (spec_c) begin
                  wb_data_d = spec_result_c;
                  state_d   = DONE;
               end else if (cache_hit_c) begin
                  wb_data_d = cache_data_c;
                  state_d   = DONE;
               end else begin
                  state_d   = RUN;
               end
            end
         end
         RUN: begin
            cnt_d = cnt_inc;
            if (div_end) begin
               // a flush racing the completion discards the result
               if (flush) begin
                  state_d = IDLE;
               end else begin
                  wb_data_d = is_rem_q ? div_remainder : div_quotient;
                  state_d   = DONE;
               end
            end else if (flush) begin
               state_d = KILL;
            end else if (cnt_inc == CNT_MAX) begin
               tmo_fire = 1'b1;
            end
         end
         KILL: begin
            cnt_d = cnt_inc;
            if (div_end) begin
               state_d = IDLE;
            end else if (cnt_inc == CNT_MAX) begin
               tmo_fire = 1'b1;
            end
         end
         DONE: begin
            if (flush || wb_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (tmo_fire) begin
         err_d     = 1'b1;
         wb_data_d = '0;
         state_d   = DONE;
      end

      div_en_d   = (state_d == RUN) || (state_d == KILL);
      wb_valid_d = (state_d == DONE);
      ex_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         is_rem_q   <= 1'b0;
         uns_q      <= 1'b0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         wb_data_q  <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         div_en_q   <= 1'b0;
         wb_valid_q <= 1'b0;
         ex_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         is_rem_q   <= is_rem_d;
         uns_q      <= uns_d;
         rs1_q      <= rs1_d;
         rs2_q      <= rs2_d;
         rd_q       <= rd_d;
         wb_data_q  <= wb_data_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         div_en_q   <= div_en_d;
         wb_valid_q <= wb_valid_d;
         ex_ready_q <= ex_ready_d;
      end
   end

`ifdef DIV_REUSE_EN
   logic                 cache_vld_q, cache_vld_d;
   logic [DATAWIDTH-1:0] cache_a_q, cache_a_d;
   logic [DATAWIDTH-1:0] cache_b_q, cache_b_d;
   logic                 cache_uns_q, cache_uns_d;
   logic [DATAWIDTH-1:0] cache_quo_q, cache_quo_d;
   logic [DATAWIDTH-1:0] cache_rem_q, cache_rem_d;

   // Remember the last divider run that actually delivered a result
   always_comb begin
      cache_vld_d  = cache_vld_q;
      cache_a_d    = cache_a_q;
      cache_b_d    = cache_b_q;
      cache_uns_d  = cache_uns_q;
      cache_quo_d  = cache_quo_q;
      cache_rem_d  = cache_rem_q;
      if (tmo_fire) begin
         cache_vld_d = 1'b0;
      end else if ((state_q == RUN) && div_end && !flush) begin
         cache_vld_d = 1'b1;
         cache_a_d   = rs1_q;
         cache_b_d   = rs2_q;
         cache_uns_d = uns_q;
         cache_quo_d = div_quotient;
         cache_rem_d = div_remainder;
      end
      cache_hit_c  = cache_vld_q && (ex_rs1 == cache_a_q) && (ex_rs2 == cache_b_q)
                     && (ex_op[0] == cache_uns_q);
      cache_data_c = ex_op[1] ? cache_rem_q : cache_quo_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_vld_q <= 1'b0;
         cache_a_q   <= '0;
         cache_b_q   <= '0;
         cache_uns_q <= 1'b0;
         cache_quo_q <= '0;
         cache_rem_q <= '0;
      end else begin
         cache_vld_q <= cache_vld_d;
         cache_a_q   <= cache_a_d;
         cache_b_q   <= cache_b_d;
         cache_uns_q <= cache_uns_d;
         cache_quo_q <= cache_quo_d;
         cache_rem_q <= cache_rem_d;
      end
   end
`else
   assign cache_hit_c  = 1'b0;
   assign cache_data_c = '0;
`endif

   assign ex_ready     = ex_ready_q;
   assign div_en       = div_en_q;
   assign div_unsigned = uns_q;
   assign div_dividend = rs1_q;
   assign div_divisor  = rs2_q;
   assign wb_valid     = wb_valid_q;
   assign wb_rd        = rd_q;
   assign wb_data      = wb_data_q;
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider and a result scoreboard.
module tb_div_issue_ctrl;
   import div_issue_ctrl_pkg::*;

   localparam int unsigned DW      = 32;
   localparam int unsigned TMO     = 64;
   localparam int unsigned DIV_LAT = 8;

   typedef struct packed {
      logic [4:0]    rd;
      logic [DW-1:0] data;
   } exp_t;

   logic          clk;
   logic          rst_n;
   logic          ex_valid;
   logic          ex_ready;
   logic [1:0]    ex_op;
   logic [DW-1:0] ex_rs1;
   logic [DW-1:0] ex_rs2;
   logic [4:0]    ex_rd;
   logic          flush;
   logic          div_en;
   logic          div_unsigned;
   logic [DW-1:0] div_dividend;
   logic [DW-1:0] div_divisor;
   logic [DW-1:0] div_quotient;
   logic [DW-1:0] div_remainder;
   logic          div_end;
   logic          wb_valid;
   logic          wb_ready;
   logic [4:0]    wb_rd;
   logic [DW-1:0] wb_data;
   logic          err_timeout;

   int   n_assert = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   bit   hang     = 1'b0;
   bit   en_seen  = 1'b0;
   int   mcnt     = 0;

   div_issue_ctrl #(.DATAWIDTH(DW), .TIMEOUT(TMO)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ex_valid     (ex_valid),
      .ex_ready     (ex_ready),
      .ex_op        (ex_op),
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .ex_rd        (ex_rd),
      .flush        (flush),
      .div_en       (div_en),
      .div_unsigned (div_unsigned),
      .div_dividend (div_dividend),
      .div_divisor  (div_divisor),
      .div_quotient (div_quotient),
      .div_remainder(div_remainder),
      .div_end      (div_end),
      .wb_valid     (wb_valid),
      .wb_ready     (wb_ready),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .err_timeout  (err_timeout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Divider model: fixed latency, pulses div_end while div_en is high unless hung
   initial begin
      div_end       = 1'b0;
      div_quotient  = '0;
      div_remainder = '0;
      forever begin
         @(posedge clk);
         #1;
         div_end = 1'b0;
         if (div_en) en_seen = 1'b1;
         if (div_en && !hang) begin
            mcnt++;
            if (mcnt == DIV_LAT) begin
               mcnt    = 0;
               div_end = 1'b1;
               if (div_divisor == '0) begin
                  div_quotient  = '1;
                  div_remainder = div_dividend;
               end else if (div_unsigned) begin
                  div_quotient  = div_dividend / div_divisor;
                  div_remainder = div_dividend % div_divisor;
               end else begin
                  div_quotient  = DW'($signed(div_dividend) / $signed(div_divisor));
                  div_remainder = DW'($signed(div_dividend) % $signed(div_divisor));
               end
            end
         end else begin
            mcnt = 0;
         end
      end
   end

   function automatic logic [DW-1:0] ref_res(input logic [1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      logic [DW-1:0] mn;
      mn = {1'b1, {(DW-1){1'b0}}};
      if (b == '0) return op[1] ? a : '1;
      if (!op[0] && a == mn && b == '1) return op[1] ? '0 : mn;
      if (op[0]) return op[1] ? a % b : a / b;
      return op[1] ? DW'($signed(a) % $signed(b)) : DW'($signed(a) / $signed(b));
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [4:0] rd, input logic [DW-1:0] res, input bit push);
      int   t;
      exp_t e;
      t = 0;
      while (!ex_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("issue_ready", DW'(ex_ready), 1);
      ex_valid = 1'b1;
      ex_op    = op;
      ex_rs1   = a;
      ex_rs2   = b;
      ex_rd    = rd;
      if (push) begin
         e.rd   = rd;
         e.data = res;
         sb.push_back(e);
      end
      @(negedge clk);
      ex_valid = 1'b0;
   endtask

   task automatic collect(input int stall);
      int   t;
      exp_t e;
      t = 0;
      while (!wb_valid && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("wb_valid_seen", DW'(wb_valid), 1);
      chk("div_en_low_in_done", DW'(div_en), 0);
      chk("sb_nonempty", DW'(sb.size() != 0), 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      repeat (stall) begin
         chk("stall_wb_valid", DW'(wb_valid), 1);
         chk("stall_wb_rd", DW'(wb_rd), DW'(e.rd));
         chk("stall_wb_data", wb_data, e.data);
         chk("stall_ex_ready", DW'(ex_ready), 0);
         @(negedge clk);
      end
      chk("wb_rd", DW'(wb_rd), DW'(e.rd));
      chk("wb_data", wb_data, e.data);
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
      chk("wb_valid_drop", DW'(wb_valid), 0);
   endtask

   initial begin
      int            t;
      int            n_en;
      logic [1:0]    rop;
      logic [DW-1:0] ra, rb;

      rst_n    = 1'b0;
      ex_valid = 1'b0;
      ex_op    = '0;
      ex_rs1   = '0;
      ex_rs2   = '0;
      ex_rd    = '0;
      flush    = 1'b0;
      wb_ready = 1'b0;
      @(negedge clk);
      chk("rst_ex_ready", DW'(ex_ready), 1);
      chk("rst_div_en", DW'(div_en), 0);
      chk("rst_wb_valid", DW'(wb_valid), 0);
      chk("rst_err", DW'(err_timeout), 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rd", DW'(wb_rd), 0);
      chk("rst_dividend", div_dividend, 0);
      chk("rst_divisor", div_divisor, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // signed divide/remainder of -7 by 2
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 1'b1);
      chk("div_en_cycle1", DW'(div_en), 1);
      chk("div_signed", DW'(div_unsigned), 0);
      chk("dividend", div_dividend, 32'hFFFF_FFF9);
      chk("divisor", div_divisor, 32'd2);
      collect(0);
      issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 1'b1);
      collect(0);

      // unsigned divide/remainder
      issue(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd3, 32'h0FFF_FFFF, 1'b1);
      chk("divu_unsigned_early", DW'(div_unsigned), 1);
      repeat (4) @(negedge clk);
      chk("divu_en_mid", DW'(div_en), 1);
      chk("divu_unsigned_mid", DW'(div_unsigned), 1);
      collect(0);
      issue(OP_REMU, 32'hFFFF_FFFF, 32'h10, 5'd4, 32'hF, 1'b1);
      collect(0);

      // special cases never launch the divider
      en_seen = 1'b0;
      issue(OP_DIVU, 32'd5, 32'd0, 5'd5, 32'hFFFF_FFFF, 1'b1);
      chk("zero_wb_valid_cycle1", DW'(wb_valid), 1);
      chk("zero_wb_data_cycle1", wb_data, 32'hFFFF_FFFF);
      collect(0);
      issue(OP_REMU, 32'd5, 32'd0, 5'd6, 32'd5, 1'b1);
      collect(0);
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1'b1);
      chk("ovf_wb_valid_cycle1", DW'(wb_valid), 1);
      collect(0);
      issue(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 1'b1);
      collect(0);
      chk("special_no_div_en", DW'(en_seen), 0);

      // flush three cycles into RUN
      issue(OP_DIV, 32'd100, 32'd3, 5'd9, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      t = 0;
      while (!div_end && t < 50) begin
         chk("kill_div_en_held", DW'(div_en), 1);
         chk("kill_no_wb_valid", DW'(wb_valid), 0);
         @(negedge clk);
         t++;
      end
      chk("kill_div_end_seen", DW'(div_end), 1);
      chk("kill_div_en_at_end", DW'(div_en), 1);
      chk("kill_ex_ready_at_end", DW'(ex_ready), 0);
      @(negedge clk);
      chk("kill_ex_ready_after", DW'(ex_ready), 1);
      chk("kill_wb_valid_after", DW'(wb_valid), 0);
      chk("kill_div_en_after", DW'(div_en), 0);
      chk("kill_sb_empty", DW'(sb.size()), 0);

      // backpressure with a second op waiting
      issue(OP_DIVU, 32'd1000, 32'd10, 5'd10, 32'd100, 1'b1);
      begin
         exp_t e2;
         ex_valid = 1'b1;
         ex_op    = OP_DIVU;
         ex_rs1   = 32'd77;
         ex_rs2   = 32'd7;
         ex_rd    = 5'd11;
         e2.rd    = 5'd11;
         e2.data  = 32'd11;
         sb.push_back(e2);
      end
      collect(3);
      chk("bp_ex_ready_after_hs", DW'(ex_ready), 1);
      @(negedge clk);
      ex_valid = 1'b0;
      chk("bp_second_accepted", DW'(ex_ready), 0);
      chk("bp_second_dividend", div_dividend, 32'd77);
      collect(0);

      // hung divider triggers the timeout
      hang = 1'b1;
      issue(OP_DIV, 32'd9, 32'd3, 5'd12, 32'd0, 1'b1);
      n_en = 0;
      t    = 0;
      while (!wb_valid && t < 200) begin
         if (div_en) n_en++;
         @(negedge clk);
         t++;
      end
      chk("tmo_run_cycles", DW'(n_en), DW'(TMO));
      chk("tmo_err", DW'(err_timeout), 1);
      collect(0);
      hang = 1'b0;
      issue(OP_DIV, 32'd50, 32'd5, 5'd13, 32'd10, 1'b1);
      collect(0);
      chk("tmo_err_sticky", DW'(err_timeout), 1);

      // same operands twice: reuse build answers the second without the divider
      issue(OP_DIV, 32'd100, 32'd7, 5'd14, 32'd14, 1'b1);
      collect(0);
      en_seen = 1'b0;
      issue(OP_REM, 32'd100, 32'd7, 5'd15, 32'd2, 1'b1);
      collect(0);
`ifdef DIV_REUSE_EN
      chk("reuse_no_div_en", DW'(en_seen), 0);
`else
      chk("noreuse_div_en", DW'(en_seen), 1);
`endif

      // a few random operations against the reference
      for (int i = 0; i < 6; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = (i % 2 == 0) ? DW'($urandom_range(0, 20)) : DW'($urandom);
         issue(rop, ra, rb, 5'(16 + i), ref_res(rop, ra, rb), 1'b1);
         collect(i % 3);
      end

      // asynchronous reset in the middle of a run
      issue(OP_DIVU, 32'd1234, 32'd5, 5'd30, 32'd0, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_div_en", DW'(div_en), 0);
      chk("arst_ex_ready", DW'(ex_ready), 1);
      chk("arst_wb_valid", DW'(wb_valid), 0);
      chk("arst_err", DW'(err_timeout), 0);
      chk("arst_dividend", div_dividend, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(OP_DIVU, 32'd40, 32'd8, 5'd31, 32'd5, 1'b1);
      collect(0);
      chk("final_sb_empty", DW'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
